// File: rtl/ram_tdp_sync_read.sv
// True dual-port RAM with registered reads, byte-enable writes and cross-port collision detect.
// Define RAM_TDP_INIT_CLEAR_EN to zero the whole array in a sweep after every reset.
module ram_tdp_sync_read #(
   parameter int WIDTH      = 8,
   parameter int DEPTH      = 64,
   parameter int RD_LATENCY = 1,
   parameter int RD_MODE    = 0,
   localparam int NUM_BYTES = WIDTH / 8,
   localparam int DEPTH_LOG = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en_a,
   input  logic                 we_n_a,
   input  logic [NUM_BYTES-1:0] be_a,
   input  logic [DEPTH_LOG-1:0] addr_a,
   input  logic [WIDTH-1:0]     data_wr_a,
   output logic [WIDTH-1:0]     data_rd_a,
   output logic                 valid_rd_a,
   input  logic                 en_b,
   input  logic                 we_n_b,
   input  logic [NUM_BYTES-1:0] be_b,
   input  logic [DEPTH_LOG-1:0] addr_b,
   input  logic [WIDTH-1:0]     data_wr_b,
   output logic [WIDTH-1:0]     data_rd_b,
   output logic                 valid_rd_b,
   output logic                 collision,
   output logic                 init_busy
);

   generate
      if ((DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
         $error("ram_tdp_sync_read: DEPTH must be a power of two");
      end
      if ((RD_LATENCY != 1) && (RD_LATENCY != 2)) begin : g_bad_latency
         $error("ram_tdp_sync_read: RD_LATENCY must be 1 or 2");
      end
      if ((WIDTH % 8) != 0) begin : g_bad_width
         $error("ram_tdp_sync_read: WIDTH must be a multiple of 8");
      end
   endgenerate

   function automatic logic [WIDTH-1:0] byte_mask(input logic [NUM_BYTES-1:0] be);
      logic [WIDTH-1:0] m;
      m = '0;
      for (int i = 0; i < NUM_BYTES; i++) begin
         m[8*i +: 8] = {8{be[i]}};
      end
      return m;
   endfunction

   logic [WIDTH-1:0]     mem_q [DEPTH];

   logic                 busy_s;
   logic                 clr_we_s;
   logic [DEPTH_LOG-1:0] clr_addr_s;

   logic                 acc_a_s, acc_b_s, wr_a_s, wr_b_s;
   logic                 same_addr_s, coll_s;
   logic [WIDTH-1:0]     old_a_s, old_b_s, mask_a_s, mask_b_s;
   logic [WIDTH-1:0]     new_a_s, new_b_s, rd_a_s, rd_b_s;

   logic [WIDTH-1:0]     rd1_a_q, rd1_b_q;
   logic                 vld1_a_q, vld1_b_q;
   logic                 coll_q;

`ifdef RAM_TDP_INIT_CLEAR_EN
   typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

   state_t               state_q, state_d;
   logic [DEPTH_LOG-1:0] clr_addr_q, clr_addr_d;

   // Sweep state register; reset always restarts the sweep from word 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_CLEAR;
         clr_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
      end
   end

   // Sweep next state: one word per cycle, back to IDLE after the last word.
   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      case (state_q)
         S_CLEAR: begin
            clr_addr_d = clr_addr_q + DEPTH_LOG'(1);
            if (clr_addr_q == DEPTH_LOG'(DEPTH - 1)) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_CLEAR;
            end
         end
         S_IDLE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign busy_s     = (state_q == S_CLEAR);
   assign clr_we_s   = busy_s & ~rst;
   assign clr_addr_s = clr_addr_q;
`else
   assign busy_s     = 1'b0;
   assign clr_we_s   = 1'b0;
   assign clr_addr_s = '0;
`endif

   assign init_busy = busy_s;

   // Access decode and word merge. On a shared address both ports see the same
   // merged word; port A owns every byte it enables, B fills only the rest.
   always_comb begin
      acc_a_s     = en_a & ~busy_s & ~rst;
      acc_b_s     = en_b & ~busy_s & ~rst;
      wr_a_s      = acc_a_s & ~we_n_a;
      wr_b_s      = acc_b_s & ~we_n_b;
      same_addr_s = (addr_a == addr_b);
      coll_s      = acc_a_s & acc_b_s & same_addr_s & (wr_a_s | wr_b_s);
      old_a_s     = mem_q[addr_a];
      old_b_s     = mem_q[addr_b];
      mask_a_s    = wr_a_s ? byte_mask(be_a) : '0;
      mask_b_s    = wr_b_s ? byte_mask(be_b) : '0;
      if (same_addr_s) begin
         mask_b_s = mask_b_s & ~mask_a_s;
         new_a_s  = (old_a_s & ~(mask_a_s | mask_b_s)) |
                    (data_wr_a & mask_a_s) | (data_wr_b & mask_b_s);
         new_b_s  = new_a_s;
      end else begin
         new_a_s  = (old_a_s & ~mask_a_s) | (data_wr_a & mask_a_s);
         new_b_s  = (old_b_s & ~mask_b_s) | (data_wr_b & mask_b_s);
      end
      // A port that only reads always sees the old word, whatever the other port does.
      rd_a_s = (wr_a_s && (RD_MODE == 1)) ? new_a_s : old_a_s;
      rd_b_s = (wr_b_s && (RD_MODE == 1)) ? new_b_s : old_b_s;
   end

   // Storage array: clear sweep has the array to itself while it runs.
   always_ff @(posedge clk) begin
      if (clr_we_s) begin
         mem_q[clr_addr_s] <= '0;
      end else begin
         if (wr_a_s) begin
            mem_q[addr_a] <= new_a_s;
         end
         if (wr_b_s) begin
            mem_q[addr_b] <= new_b_s;
         end
      end
   end

   // First read stage and collision flag; read data holds between accesses.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd1_a_q  <= '0;
         rd1_b_q  <= '0;
         vld1_a_q <= 1'b0;
         vld1_b_q <= 1'b0;
         coll_q   <= 1'b0;
      end else begin
         vld1_a_q <= acc_a_s;
         vld1_b_q <= acc_b_s;
         coll_q   <= coll_s;
         if (acc_a_s) begin
            rd1_a_q <= rd_a_s;
         end
         if (acc_b_s) begin
            rd1_b_q <= rd_b_s;
         end
      end
   end

   assign collision = coll_q;

   generate
      if (RD_LATENCY == 2) begin : g_lat2
         logic [WIDTH-1:0] rd2_a_q, rd2_b_q;
         logic             vld2_a_q, vld2_b_q;

         // Extra output register stage.
         always_ff @(posedge clk) begin
            if (rst) begin
               rd2_a_q  <= '0;
               rd2_b_q  <= '0;
               vld2_a_q <= 1'b0;
               vld2_b_q <= 1'b0;
            end else begin
               vld2_a_q <= vld1_a_q;
               vld2_b_q <= vld1_b_q;
               if (vld1_a_q) begin
                  rd2_a_q <= rd1_a_q;
               end
               if (vld1_b_q) begin
                  rd2_b_q <= rd1_b_q;
               end
            end
         end

         assign data_rd_a  = rd2_a_q;
         assign data_rd_b  = rd2_b_q;
         assign valid_rd_a = vld2_a_q;
         assign valid_rd_b = vld2_b_q;
      end else begin : g_lat1
         assign data_rd_a  = rd1_a_q;
         assign data_rd_b  = rd1_b_q;
         assign valid_rd_a = vld1_a_q;
         assign valid_rd_b = vld1_b_q;
      end
   endgenerate

endmodule

// File: tb/tb_ram_tdp_sync_read.sv
// Scoreboard bench: dut0 = defaults (8b, latency 1, read-first), dut1 = 16b, latency 2, write-first.
module tb_ram_tdp_sync_read;

   typedef struct {
      int          port;
      int          due;
      logic [15:0] data;
   } exp_t;

   logic        clk, rst;
   logic        en_a, we_n_a, en_b, we_n_b;
   logic [5:0]  addr_a, addr_b;
   logic        be0_a, be0_b;
   logic [7:0]  d0_a, d0_b, q0_a, q0_b;
   logic [1:0]  be1_a, be1_b;
   logic [15:0] d1_a, d1_b, q1_a, q1_b;
   logic        v0_a, v0_b, v1_a, v1_b, col0, col1, busy0, busy1;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc     = 0;
   bit          mon_en  = 1'b0;
   bit          exp_coll = 1'b0;
   exp_t        sb[$];
   logic [15:0] model [2][64];
   logic [15:0] mon_q [4];
   logic        mon_v [4];
   int          mon_idx;

   ram_tdp_sync_read dut0 (
      .clk(clk), .rst(rst),
      .en_a(en_a), .we_n_a(we_n_a), .be_a(be0_a), .addr_a(addr_a), .data_wr_a(d0_a),
      .data_rd_a(q0_a), .valid_rd_a(v0_a),
      .en_b(en_b), .we_n_b(we_n_b), .be_b(be0_b), .addr_b(addr_b), .data_wr_b(d0_b),
      .data_rd_b(q0_b), .valid_rd_b(v0_b),
      .collision(col0), .init_busy(busy0)
   );

   ram_tdp_sync_read #(.WIDTH(16), .DEPTH(64), .RD_LATENCY(2), .RD_MODE(1)) dut1 (
      .clk(clk), .rst(rst),
      .en_a(en_a), .we_n_a(we_n_a), .be_a(be1_a), .addr_a(addr_a), .data_wr_a(d1_a),
      .data_rd_a(q1_a), .valid_rd_a(v1_a),
      .en_b(en_b), .we_n_b(we_n_b), .be_b(be1_b), .addr_b(addr_b), .data_wr_b(d1_b),
      .data_rd_b(q1_b), .valid_rd_b(v1_b),
      .collision(col1), .init_busy(busy1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard monitor: every valid must match the oldest outstanding read of that port, on time.
   always @(negedge clk) begin
      if (mon_en) begin
         mon_v = '{v0_a, v0_b, v1_a, v1_b};
         mon_q = '{{8'h00, q0_a}, {8'h00, q0_b}, q1_a, q1_b};
         for (int p = 0; p < 4; p++) begin
            mon_idx = -1;
            for (int j = 0; j < sb.size(); j++) begin
               if (mon_idx < 0 && sb[j].port == p) mon_idx = j;
            end
            if (mon_v[p] === 1'b1) begin
               n_tests++;
               if (mon_idx < 0) begin
                  n_fail++;
                  $display("FAIL rd_unexpected port%0d: valid=1 data=%h at cycle %0d, required no read outstanding",
                           p, mon_q[p], cyc);
               end else begin
                  if (sb[mon_idx].due != cyc || mon_q[p] !== sb[mon_idx].data) begin
                     n_fail++;
                     $display("FAIL rd_data port%0d: got %h at cycle %0d, required %h at cycle %0d",
                              p, mon_q[p], cyc, sb[mon_idx].data, sb[mon_idx].due);
                  end
                  sb.delete(mon_idx);
               end
            end else if (mon_idx >= 0 && sb[mon_idx].due <= cyc) begin
               n_tests++;
               n_fail++;
               $display("FAIL rd_missing port%0d: valid=%b at cycle %0d, required data %h at cycle %0d",
                        p, mon_v[p], cyc, sb[mon_idx].data, sb[mon_idx].due);
               sb.delete(mon_idx);
            end
         end
         n_tests++;
         if (col0 !== exp_coll || col1 !== exp_coll) begin
            n_fail++;
            $display("FAIL collision: got dut0=%b dut1=%b at cycle %0d, required %b", col0, col1, cyc, exp_coll);
         end
      end
   end

   // One access cycle on both ports: model predicts read results and memory update.
   task automatic tick(input bit ea, input bit wna, input logic [1:0] bea, input logic [5:0] aa,
                       input logic [15:0] da, input bit eb, input bit wnb, input logic [1:0] beb,
                       input logic [5:0] ab, input logic [15:0] db);
      logic [15:0] old_a, old_b;
      logic [15:0] new_a [2];
      logic [15:0] new_b [2];
      bit          wra, wrb, same, coll_n;
      int          nbytes;
      exp_t        e;
      en_a = ea; we_n_a = wna; addr_a = aa; be0_a = bea[0]; be1_a = bea; d0_a = da[7:0]; d1_a = da;
      en_b = eb; we_n_b = wnb; addr_b = ab; be0_b = beb[0]; be1_b = beb; d0_b = db[7:0]; d1_b = db;
      wra    = ea && !wna;
      wrb    = eb && !wnb;
      same   = (aa == ab);
      coll_n = ea && eb && same && (wra || wrb);
      for (int k = 0; k < 2; k++) begin
         nbytes   = (k == 0) ? 1 : 2;
         old_a    = model[k][aa];
         old_b    = model[k][ab];
         new_a[k] = old_a;
         new_b[k] = old_b;
         for (int i = 0; i < nbytes; i++) begin
            if (wra && bea[i]) new_a[k][8*i +: 8] = da[8*i +: 8];
            else if (wrb && same && beb[i]) new_a[k][8*i +: 8] = db[8*i +: 8];
            if (wrb && beb[i] && !(wra && same && bea[i])) new_b[k][8*i +: 8] = db[8*i +: 8];
            else if (wra && same && bea[i]) new_b[k][8*i +: 8] = da[8*i +: 8];
         end
         e.due = cyc + k + 1;
         if (ea) begin
            e.port = 2 * k;
            e.data = (wra && k == 1) ? new_a[k] : old_a;
            sb.push_back(e);
         end
         if (eb) begin
            e.port = 2 * k + 1;
            e.data = (wrb && k == 1) ? new_b[k] : old_b;
            sb.push_back(e);
         end
      end
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         if (wrb) model[k][ab] = new_b[k];
         if (wra) model[k][aa] = new_a[k];
      end
      exp_coll = coll_n;
      @(negedge clk);
      en_a = 1'b0;
      en_b = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(0, 1, 2'b00, 6'd0, 16'h0, 0, 1, 2'b00, 6'd0, 16'h0);
   endtask

   // Waits out the clear sweep (if built in) and mirrors it in the model.
   task automatic wait_clear();
`ifdef RAM_TDP_INIT_CLEAR_EN
      for (int i = 0; i < 200 && busy0 === 1'b1; i++) @(negedge clk);
      n_tests++;
      if (busy0 !== 1'b0 || busy1 !== 1'b0) begin
         n_fail++;
         $display("FAIL clear_timeout: init_busy dut0=%b dut1=%b after 200 cycles, required 0", busy0, busy1);
      end
      for (int k = 0; k < 2; k++) for (int a = 0; a < 64; a++) model[k][a] = 16'h0000;
`endif
   endtask

   task automatic do_reset();
      rst = 1'b1; en_a = 1'b0; en_b = 1'b0;
      @(posedge clk);
      sb.delete();
      exp_coll = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      wait_clear();
   endtask

   task automatic test_reset();
      rst = 1'b1; en_a = 1'b0; en_b = 1'b0; we_n_a = 1'b1; we_n_b = 1'b1;
      addr_a = 6'd0; addr_b = 6'd0; be0_a = 1'b0; be0_b = 1'b0; be1_a = 2'b00; be1_b = 2'b00;
      d0_a = 8'h00; d0_b = 8'h00; d1_a = 16'h0; d1_b = 16'h0;
      repeat (3) @(negedge clk);
      n_tests++;
      if ({v0_a, v0_b, v1_a, v1_b, col0, col1} !== 6'b000000 || {q0_a, q0_b} !== 16'h0000 ||
          {q1_a, q1_b} !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: valid=%b%b%b%b col=%b%b q0=%h/%h q1=%h/%h, required all 0",
                  v0_a, v0_b, v1_a, v1_b, col0, col1, q0_a, q0_b, q1_a, q1_b);
      end
      n_tests++;
`ifdef RAM_TDP_INIT_CLEAR_EN
      if (busy0 !== 1'b1 || busy1 !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_busy: init_busy=%b/%b, required 1", busy0, busy1);
      end
`else
      if (busy0 !== 1'b0 || busy1 !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_busy: init_busy=%b/%b, required 0", busy0, busy1);
      end
`endif
      rst = 1'b0;
      wait_clear();
   endtask

   task automatic test_basic();
      tick(1, 0, 2'b11, 6'd3, 16'h00A5, 0, 1, 2'b00, 6'd0, 16'h0);
      tick(0, 1, 2'b00, 6'd0, 16'h0, 1, 1, 2'b00, 6'd3, 16'h0);
      n_tests++;
      if (v0_b !== 1'b1 || q0_b !== 8'hA5) begin
         n_fail++;
         $display("FAIL basic_read: valid=%b data=%h, required 1/a5", v0_b, q0_b);
      end
      idle(1);
      n_tests++;
      if (v0_b !== 1'b0 || q0_b !== 8'hA5 || v1_b !== 1'b1 || q1_b !== 16'h00A5) begin
         n_fail++;
         $display("FAIL basic_hold: dut0 %b/%h dut1 %b/%h, required 0/a5 1/00a5", v0_b, q0_b, v1_b, q1_b);
      end
      idle(1);
   endtask

   task automatic test_byte_enable();
      tick(1, 0, 2'b11, 6'd7, 16'h1234, 0, 1, 2'b00, 6'd0, 16'h0);
      tick(1, 0, 2'b01, 6'd7, 16'hABCD, 0, 1, 2'b00, 6'd0, 16'h0);
      tick(1, 1, 2'b00, 6'd7, 16'h0, 0, 1, 2'b00, 6'd0, 16'h0);
      n_tests++;
      if (q0_a !== 8'hCD) begin
         n_fail++;
         $display("FAIL be_dut0: data=%h, required cd", q0_a);
      end
      idle(1);
      n_tests++;
      if (q1_a !== 16'h12CD) begin
         n_fail++;
         $display("FAIL be_dut1: data=%h, required 12cd", q1_a);
      end
      tick(1, 0, 2'b00, 6'd7, 16'hFFFF, 0, 1, 2'b00, 6'd0, 16'h0);
      tick(0, 1, 2'b00, 6'd0, 16'h0, 1, 1, 2'b00, 6'd7, 16'h0);
      idle(2);
   endtask

   task automatic test_rdw_mode();
      tick(1, 0, 2'b11, 6'd5, 16'h0011, 0, 1, 2'b00, 6'd0, 16'h0);
      tick(1, 0, 2'b11, 6'd5, 16'h0022, 0, 1, 2'b00, 6'd0, 16'h0);
      n_tests++;
      if (q0_a !== 8'h11) begin
         n_fail++;
         $display("FAIL rdw_read_first: data=%h, required 11", q0_a);
      end
      tick(1, 1, 2'b00, 6'd5, 16'h0, 0, 1, 2'b00, 6'd0, 16'h0);
      n_tests++;
      if (q1_a !== 16'h0022 || q0_a !== 8'h22) begin
         n_fail++;
         $display("FAIL rdw_write_first: dut1=%h dut0=%h, required 0022/22", q1_a, q0_a);
      end
      idle(2);
   endtask

   task automatic test_collision();
      tick(1, 0, 2'b11, 6'd9, 16'h000F, 1, 0, 2'b11, 6'd9, 16'h00F0);
      n_tests++;
      if (col0 !== 1'b1 || col1 !== 1'b1) begin
         n_fail++;
         $display("FAIL coll_ww: collision=%b/%b, required 1", col0, col1);
      end
      tick(1, 1, 2'b00, 6'd9, 16'h0, 0, 1, 2'b00, 6'd0, 16'h0);
      n_tests++;
      if (col0 !== 1'b0 || q0_a !== 8'h0F) begin
         n_fail++;
         $display("FAIL coll_ww_result: collision=%b data=%h, required 0/0f", col0, q0_a);
      end
      tick(1, 1, 2'b00, 6'd9, 16'h0, 1, 0, 2'b11, 6'd9, 16'h0077);
      n_tests++;
      if (col0 !== 1'b1 || col1 !== 1'b1 || q0_a !== 8'h0F || q1_a !== 16'h000F) begin
         n_fail++;
         $display("FAIL coll_rw: col=%b/%b q0=%h q1=%h, required 1/1 0f 000f", col0, col1, q0_a, q1_a);
      end
      idle(1);
      n_tests++;
      if (q1_a !== 16'h000F) begin
         n_fail++;
         $display("FAIL coll_rw_old: dut1 data=%h, required 000f", q1_a);
      end
      tick(1, 0, 2'b01, 6'd10, 16'h1111, 1, 0, 2'b11, 6'd10, 16'h2222);
      tick(1, 1, 2'b00, 6'd10, 16'h0, 1, 1, 2'b00, 6'd9, 16'h0);
      tick(1, 1, 2'b00, 6'd9, 16'h0, 1, 1, 2'b00, 6'd9, 16'h0);
      n_tests++;
      if (col0 !== 1'b0 || col1 !== 1'b0) begin
         n_fail++;
         $display("FAIL coll_rr: collision=%b/%b, required 0", col0, col1);
      end
      idle(2);
   endtask

   task automatic test_latency2();
      tick(1, 0, 2'b11, 6'd0, 16'h0030, 1, 0, 2'b11, 6'd1, 16'h0031);
      tick(1, 0, 2'b11, 6'd2, 16'h0032, 0, 1, 2'b00, 6'd0, 16'h0);
      idle(2);
      for (int r = 0; r < 5; r++) begin
         if (r < 3) tick(1, 1, 2'b00, 6'(r), 16'h0, 0, 1, 2'b00, 6'd0, 16'h0);
         else idle(1);
         n_tests++;
         if (v1_a !== (r >= 1 && r <= 3) || (r >= 1 && r <= 3 && q1_a !== 16'h0030 + 16'(r - 1))) begin
            n_fail++;
            $display("FAIL lat2_stream step%0d: valid=%b data=%h", r, v1_a, q1_a);
         end
      end
      for (int r = 0; r < 3; r++) tick(1, 1, 2'b00, 6'(r), 16'h0, 0, 1, 2'b00, 6'd0, 16'h0);
      rst = 1'b1;
      @(posedge clk);
      sb.delete();
      exp_coll = 1'b0;
      @(negedge clk);
      n_tests++;
      if (v1_a !== 1'b0 || v0_a !== 1'b0) begin
         n_fail++;
         $display("FAIL lat2_reset: valid=%b/%b, required 0", v0_a, v1_a);
      end
      rst = 1'b0;
      wait_clear();
   endtask

   task automatic test_random();
      for (int i = 0; i < 32; i++)
         tick(1, 0, 2'b11, 6'(i), 16'($urandom), 1, 0, 2'b11, 6'(i + 32), 16'($urandom));
      for (int i = 0; i < 400; i++)
         tick(1'($urandom), 1'($urandom), 2'($urandom), 6'($urandom_range(0, 7)), 16'($urandom),
              1'($urandom), 1'($urandom), 2'($urandom), 6'($urandom_range(0, 7)), 16'($urandom));
      idle(3);
   endtask

`ifdef RAM_TDP_INIT_CLEAR_EN
   task automatic test_init_clear();
      int n;
      for (int i = 0; i < 32; i++)
         tick(1, 0, 2'b11, 6'(i), 16'hFFFF, 1, 0, 2'b11, 6'(i + 32), 16'hFFFF);
      idle(3);
      for (int pass = 0; pass < 2; pass++) begin
         rst = 1'b1;
         @(posedge clk);
         sb.delete();
         exp_coll = 1'b0;
         @(negedge clk);
         rst = 1'b0;
         n = 0;
         while (busy0 === 1'b1 && n < 200 && !(pass == 0 && n == 30)) begin
            n++;
            en_a = (n == 10); we_n_a = 1'b0; addr_a = 6'd4; be0_a = 1'b1; be1_a = 2'b11;
            d0_a = 8'hFF; d1_a = 16'hFFFF;
            @(negedge clk);
         end
         en_a = 1'b0;
         n_tests++;
         if (n != ((pass == 0) ? 30 : 64) || busy1 !== busy0) begin
            n_fail++;
            $display("FAIL clear_busy pass%0d: busy cycles=%0d dut1 busy=%b, required %0d", pass, n, busy1,
                     (pass == 0) ? 30 : 64);
         end
      end
      for (int k = 0; k < 2; k++) for (int a = 0; a < 64; a++) model[k][a] = 16'h0000;
      for (int i = 0; i < 32; i++)
         tick(1, 1, 2'b00, 6'(i), 16'h0, 1, 1, 2'b00, 6'(i + 32), 16'h0);
      idle(3);
   endtask
`endif

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      mon_en = 1'b1;
      test_basic();
      test_byte_enable();
      test_rdw_mode();
      test_collision();
      test_latency2();
      test_random();
`ifdef RAM_TDP_INIT_CLEAR_EN
      test_init_clear();
`endif
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d reads outstanding, required 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ram_tdp_sync_read.md
Name: ram_tdp_sync_read

Overview:
Parametrised true dual-port RAM: the successor to the single-write/async-read dual-port RAM.
- Two symmetric ports A and B; each can read or write on any cycle.
- Synchronous registered read with selectable latency.
- Byte-enable writes, selectable same-port read-during-write mode, cross-port collision detection.
- Used as a shared buffer between two clients in the same clock domain.

Parameters:
WIDTH, 8, data width in bits; must be a multiple of 8; NUM_BYTES = WIDTH/8 (derived)
DEPTH, 64, number of words; DEPTH_LOG = $clog2(DEPTH) (derived)
RD_LATENCY, 1, read latency in cycles; legal values 1 or 2 (2 adds an output register stage)
RD_MODE, 0, same-port read-during-write: 0 = read-first (old word), 1 = write-first (new merged word)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
en_a  input  1  port A access enable
we_n_a  input  1  port A write enable, active-low; en_a=1, we_n_a=0 is a write, en_a=1, we_n_a=1 is a read
be_a  input  NUM_BYTES  port A byte enables for writes
addr_a  input  DEPTH_LOG  port A address
data_wr_a  input  WIDTH  port A write data
data_rd_a  output  WIDTH  port A read data
valid_rd_a  output  1  port A read data valid
en_b, we_n_b, be_b, addr_b, data_wr_b, data_rd_b, valid_rd_b: same as port A, for port B
collision  output  1  one-cycle pulse on a same-address conflict
init_busy  output  1  clear sweep in progress (see Optional Feature)

Behaviour:
- Decided: one clock, clk; reset rst is synchronous and active-high.
- Reset values: data_rd_a/b = 0, valid_rd_a/b = 0, collision = 0, pipeline registers = 0. Memory array is not reset, except under the optional feature.
- Write (en=1, we_n=0): at the clk edge, byte i of the word is updated from data_wr[8i+7:8i] only where be[i]=1. be = 0 writes nothing but still counts as an access.
- Every enabled access (read or write) produces a read result. data_rd and valid_rd are updated RD_LATENCY edges after the access edge.
- valid_rd is 1 for exactly one cycle per access. Back-to-back accesses give continuous valid.
- data_rd holds its last value while valid_rd = 0.
- Same-port write:
  - RD_MODE=0: returned word is the pre-write contents.
  - RD_MODE=1: returned word is the post-write merged word.
- Cross-port collision: both en=1, addr_a == addr_b, at least one port writing.
  - collision pulses high for the cycle after the access edge (latency 1, independent of RD_LATENCY).
  - Write/write: port A's enabled bytes win; port B writes only bytes where be_b=1 and be_a=0.
  - Read/write: the reading port always returns the old word, regardless of RD_MODE.
  - Both reading the same address: not a collision; both ports get the stored word.
- Addresses wrap naturally within DEPTH_LOG bits. DEPTH must be a power of two; non-power-of-two DEPTH is a configuration error (elaboration $error).
- Reset asserted mid-operation: in-flight reads are discarded; valid_rd = 0 on the next cycle.

Optional Feature:
Macro RAM_TDP_INIT_CLEAR_EN.
- Defined: a two-state FSM (IDLE, CLEAR).
  - rst forces CLEAR with the sweep address at 0.
  - In CLEAR, one word per cycle is written to 0, addresses 0..DEPTH-1, so the sweep takes DEPTH cycles.
  - init_busy = 1 in CLEAR. Port accesses are ignored: no writes, no valid_rd, no collision.
  - After address DEPTH-1 the FSM goes to IDLE and init_busy = 0.
  - rst during CLEAR restarts the sweep at address 0.
- Undefined: no FSM; init_busy is tied 0; memory contents are undefined until written; ports are usable on the first cycle after reset.

Test Plan:
1. Defaults, RD_LATENCY=1: port A writes 0xA5 at address 3; the next cycle port B reads address 3 -> data_rd_b = 0xA5 with valid_rd_b = 1 exactly one cycle after the read edge.
2. WIDTH=16: write 0x1234 at address 7 with be=2'b11, then 0xABCD with be=2'b01 -> read of address 7 returns 0x12CD.
3. RD_MODE=0 vs 1: address 5 holds 0x11; port A writes 0x22 to address 5 -> data_rd_a = 0x11 (RD_MODE=0) or 0x22 (RD_MODE=1); a following read returns 0x22 in both modes.
4. Same cycle: A writes 0x0F and B writes 0xF0 to address 9, both be=1 -> collision pulses for 1 cycle; a later read returns 0x0F. Same cycle: A reads and B writes 0x77 at address 9 -> A gets 0x0F, collision = 1.
5. RD_LATENCY=2: reads of addresses 0,1,2 on consecutive cycles -> valid_rd high for 3 consecutive cycles starting 2 cycles after the first read, data returned in order. Assert rst mid-stream -> valid_rd = 0 on the next cycle.
6. With RAM_TDP_INIT_CLEAR_EN: fill the RAM with 0xFF, pulse rst -> init_busy high for 64 cycles; a write attempted during the sweep is ignored; afterwards every address reads 0x00. Reassert rst at sweep cycle 30 -> init_busy stays high for another 64 cycles.
